// File: rtl/spi_burst_deserializer.sv
// spi_burst_deserializer
//   Oversampling SPI receiver for IMU burst reads. The SPI lines are sampled
//   on the system clock. After CS falls, the command/address bits are skipped.
//   The receiver then assembles NUM_WORDS words of WORD_W bits (MSB-first on
//   the wire), applies the byte order, tags each word with its channel index,
//   and pushes it into a small output FIFO.
//
// Ports:
//   clk, rst          system clock (>= 4x SCK); synchronous active-high reset
//   rp2350_sck/cs/miso asynchronous SPI inputs (CS active low)
//   out_data/out_chan FIFO head word and its channel index (0 while empty)
//   out_valid/ready   output handshake
//   frame_done        1-cycle pulse when the last word of a frame completes
//   short_frame       1-cycle pulse when CS rises before the frame completes
//   overrun           sticky flag: a completed word was dropped on a full FIFO
//
// Handshake: a word transfers on every clk edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data and out_chan hold
// their values, and out_valid stays high.

module spi_burst_deserializer #(
    parameter int WORD_W        = 16,
    parameter int NUM_WORDS     = 6,
    parameter int SKIP_BITS     = 8,
    parameter int LITTLE_ENDIAN = 1,
    parameter int FIFO_DEPTH    = 8,
    localparam int CHW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rp2350_sck,
    input  logic              rp2350_cs,
    input  logic              rp2350_miso,
    output logic [WORD_W-1:0] out_data,
    output logic [CHW-1:0]    out_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              short_frame,
    output logic              overrun
);
    localparam int NB   = WORD_W / 8;
    localparam int MAXC = (WORD_W > SKIP_BITS) ? WORD_W : SKIP_BITS;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int EW   = CHW + WORD_W;

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, SKIP, DATA, DONE} state_t;

    // Two-flop synchronisers, plus one extra flop on SCK and CS for edge
    // detection. The CS chain resets low, so that after reset the receiver
    // waits until it observes a real CS-high level. A frame that is already
    // in progress at reset release is therefore never mistaken for a fresh
    // CS fall.
    logic sck_s1, sck_s2, sck_d;
    logic cs_s1, cs_s2, cs_d;
    logic miso_s1, miso_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_d <= 1'b0;
            cs_s1  <= 1'b0; cs_s2  <= 1'b0; cs_d  <= 1'b0;
            miso_s1 <= 1'b0; miso_s2 <= 1'b0;
        end else begin
            sck_s1  <= rp2350_sck;  sck_s2  <= sck_s1;  sck_d <= sck_s2;
            cs_s1   <= rp2350_cs;   cs_s2   <= cs_s1;   cs_d  <= cs_s2;
            miso_s1 <= rp2350_miso; miso_s2 <= miso_s1;
        end
    end

    logic sck_rise, cs_fall, cs_rise;
    assign sck_rise = sck_s2 & ~sck_d;
    assign cs_fall  = ~cs_s2 & cs_d;
    assign cs_rise  = cs_s2 & ~cs_d;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CHW-1:0]    chan;
    logic [WORD_W-1:0] shift_reg;

    // Word assembly. The completing bit is taken straight from the
    // synchroniser, so the finished word can be pushed in the same cycle.
    logic [WORD_W-1:0] rx_word, word;
    logic              word_done;

    always_comb begin
        rx_word = {shift_reg[WORD_W-2:0], miso_s2};
        word    = rx_word;
        if (LITTLE_ENDIAN != 0) begin
            for (int k = 0; k < NB; k++)
                word[8*k +: 8] = rx_word[8*(NB-1-k) +: 8];
        end
    end

    // cs_rise takes priority over a coincident sck_rise.
    assign word_done = (state == DATA) && sck_rise && !cs_rise &&
                       (int'(cnt) == WORD_W - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_IDLE;
            cnt         <= '0;
            chan        <= '0;
            shift_reg   <= '0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
            case (state)
                WAIT_IDLE: if (cs_s2) state <= IDLE;
                IDLE: if (cs_fall) begin
                    cnt       <= '0;
                    chan      <= '0;
                    shift_reg <= '0;
                    state     <= (SKIP_BITS == 0) ? DATA : SKIP;
                end
                SKIP: if (cs_rise) begin
                    short_frame <= 1'b1;
                    state       <= IDLE;
                end else if (sck_rise) begin
                    if (int'(cnt) == SKIP_BITS - 1) begin
                        cnt   <= '0;
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: if (cs_rise) begin
                    short_frame <= 1'b1;
                    state       <= IDLE;
                end else if (sck_rise) begin
                    shift_reg <= rx_word;
                    if (word_done) begin
                        cnt <= '0;
                        if (int'(chan) == NUM_WORDS - 1) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            chan <= chan + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (cs_rise) state <= IDLE;
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    // Output FIFO. The head is read combinationally from registered
    // pointers. When the FIFO is full, a push and a pop in the same cycle
    // both proceed: the write lands in the slot that is being vacated.
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = word_done && (!full || pop);
    assign {out_chan, out_data} = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {chan, word};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (word_done && full && !pop) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_burst_deserializer.sv
module tb_spi_burst_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0, cs = 1'b1, miso = 1'b0;

    always #5 clk = ~clk;

    // u_le: default parameters; u_be: big-endian; u_d4: 4-deep FIFO;
    // u_w24: 24-bit single word with no skip phase.
    logic [15:0] d_le, d_be, d_d4;
    logic [23:0] d_w24;
    logic [2:0]  c_le, c_be, c_d4;
    logic [0:0]  c_w24;
    logic v_le, v_be, v_d4, v_w24;
    logic r_le = 1'b1, r_be = 1'b1, r_d4 = 1'b1, r_w24 = 1'b1;
    logic fd_le, fd_be, fd_d4, fd_w24;
    logic sf_le, sf_be, sf_d4, sf_w24;
    logic ov_le, ov_be, ov_d4, ov_w24;

    spi_burst_deserializer u_le (
        .clk(clk), .rst(rst), .rp2350_sck(sck), .rp2350_cs(cs), .rp2350_miso(miso),
        .out_data(d_le), .out_chan(c_le), .out_valid(v_le), .out_ready(r_le),
        .frame_done(fd_le), .short_frame(sf_le), .overrun(ov_le));
    spi_burst_deserializer #(.LITTLE_ENDIAN(0)) u_be (
        .clk(clk), .rst(rst), .rp2350_sck(sck), .rp2350_cs(cs), .rp2350_miso(miso),
        .out_data(d_be), .out_chan(c_be), .out_valid(v_be), .out_ready(r_be),
        .frame_done(fd_be), .short_frame(sf_be), .overrun(ov_be));
    spi_burst_deserializer #(.FIFO_DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .rp2350_sck(sck), .rp2350_cs(cs), .rp2350_miso(miso),
        .out_data(d_d4), .out_chan(c_d4), .out_valid(v_d4), .out_ready(r_d4),
        .frame_done(fd_d4), .short_frame(sf_d4), .overrun(ov_d4));
    spi_burst_deserializer #(.WORD_W(24), .NUM_WORDS(1), .SKIP_BITS(0)) u_w24 (
        .clk(clk), .rst(rst), .rp2350_sck(sck), .rp2350_cs(cs), .rp2350_miso(miso),
        .out_data(d_w24), .out_chan(c_w24), .out_valid(v_w24), .out_ready(r_w24),
        .frame_done(fd_w24), .short_frame(sf_w24), .overrun(ov_w24));

    // Scoreboard: every popped word is logged as {chan, data}; pulses are counted.
    logic [39:0] got_le[$], got_be[$], got_d4[$], got_w24[$];
    int fdn_le = 0, fdn_be = 0, fdn_d4 = 0, fdn_w24 = 0;
    int sfn_le = 0, sfn_w24 = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (v_le && r_le)   got_le.push_back({8'(c_le), 32'(d_le)});
            if (v_be && r_be)   got_be.push_back({8'(c_be), 32'(d_be)});
            if (v_d4 && r_d4)   got_d4.push_back({8'(c_d4), 32'(d_d4)});
            if (v_w24 && r_w24) got_w24.push_back({8'(c_w24), 32'(d_w24)});
            if (fd_le)  fdn_le++;
            if (fd_be)  fdn_be++;
            if (fd_d4)  fdn_d4++;
            if (fd_w24) fdn_w24++;
            if (sf_le)  sfn_le++;
            if (sf_w24) sfn_w24++;
        end
    end

    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] ent(input int ch, input logic [31:0] d);
        return {8'(ch), d};
    endfunction

    // Mode-0 SPI driver: MISO changes while SCK is low; SCK is 8x slower than clk.
    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            miso = b[7-i];
            #40 sck = 1'b1;
            #40 sck = 1'b0;
        end
    endtask

    logic [7:0] fr[$];

    task automatic send_bytes();
        foreach (fr[i]) spi_bits(fr[i], 8);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        #100 cs = 1'b1;
        #400;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    int n0, n1, f0, s0;

    initial begin
        fr = '{8'hA2, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A,
               8'hF0, 8'hDE, 8'h11, 8'h00, 8'hFF, 8'h7F};

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        chk("rst_valid", 64'(v_le), 64'd0);
        chk("rst_data", 64'(d_le), 64'd0);
        chk("rst_chan", 64'(c_le), 64'd0);
        chk("rst_fd_sf_ov", {61'd0, fd_le, sf_le, ov_le}, 64'd0);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // Full 6-word frame, little- and big-endian instances together
        n0 = got_le.size(); n1 = got_be.size(); f0 = fdn_le; s0 = sfn_le;
        cs_low(); send_bytes(); cs_high();
        chk("le_count", 64'(got_le.size() - n0), 64'd6);
        chk("le_w0", 64'(got_le[n0+0]), 64'(ent(0, 32'h1234)));
        chk("le_w1", 64'(got_le[n0+1]), 64'(ent(1, 32'h5678)));
        chk("le_w2", 64'(got_le[n0+2]), 64'(ent(2, 32'h9ABC)));
        chk("le_w3", 64'(got_le[n0+3]), 64'(ent(3, 32'hDEF0)));
        chk("le_w4", 64'(got_le[n0+4]), 64'(ent(4, 32'h0011)));
        chk("le_w5", 64'(got_le[n0+5]), 64'(ent(5, 32'h7FFF)));
        chk("le_frame_done", 64'(fdn_le - f0), 64'd1);
        chk("le_short", 64'(sfn_le - s0), 64'd0);
        chk("le_overrun", 64'(ov_le), 64'd0);
        chk("be_count", 64'(got_be.size() - n1), 64'd6);
        chk("be_w0", 64'(got_be[n1+0]), 64'(ent(0, 32'h3412)));
        chk("be_w5", 64'(got_be[n1+5]), 64'(ent(5, 32'hFF7F)));

        // Short frame: command + 3 bytes, then a full frame
        do_reset();
        n0 = got_le.size(); f0 = fdn_le; s0 = sfn_le;
        fr = '{8'hA2, 8'h34, 8'h12, 8'h78};
        cs_low(); send_bytes(); cs_high();
        chk("short_count", 64'(got_le.size() - n0), 64'd1);
        chk("short_w0", 64'(got_le[n0]), 64'(ent(0, 32'h1234)));
        chk("short_pulse", 64'(sfn_le - s0), 64'd1);
        chk("short_no_fd", 64'(fdn_le - f0), 64'd0);
        fr = '{8'hA2, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A,
               8'hF0, 8'hDE, 8'h11, 8'h00, 8'hFF, 8'h7F};
        cs_low(); send_bytes(); cs_high();
        chk("after_short_count", 64'(got_le.size() - n0), 64'd7);
        chk("after_short_w0", 64'(got_le[n0+1]), 64'(ent(0, 32'h1234)));
        chk("after_short_w5", 64'(got_le[n0+6]), 64'(ent(5, 32'h7FFF)));

        // Overrun on a 4-deep FIFO with out_ready low
        do_reset();
        r_d4 = 1'b0;
        f0 = fdn_d4;
        cs_low(); send_bytes(); cs_high();
        chk("d4_overrun", 64'(ov_d4), 64'd1);
        chk("d4_frame_done", 64'(fdn_d4 - f0), 64'd1);
        chk("d4_valid_held", 64'(v_d4), 64'd1);
        chk("d4_head_held", {24'd0, 8'(c_d4), 32'(d_d4)}, 64'(ent(0, 32'h1234)));
        n0 = got_d4.size();
        @(posedge clk); #1 r_d4 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("d4_drain_count", 64'(got_d4.size() - n0), 64'd4);
        chk("d4_d0", 64'(got_d4[n0+0]), 64'(ent(0, 32'h1234)));
        chk("d4_d1", 64'(got_d4[n0+1]), 64'(ent(1, 32'h5678)));
        chk("d4_d2", 64'(got_d4[n0+2]), 64'(ent(2, 32'h9ABC)));
        chk("d4_d3", 64'(got_d4[n0+3]), 64'(ent(3, 32'hDEF0)));
        chk("d4_empty", 64'(v_d4), 64'd0);
        chk("d4_overrun_sticky", 64'(ov_d4), 64'd1);

        // Reset while CS is low in the middle of a word
        do_reset();
        r_le = 1'b0;
        cs_low();
        spi_bits(8'hA2, 8); spi_bits(8'h34, 8); spi_bits(8'h12, 8); spi_bits(8'h78, 4);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_valid_before_rst", 64'(v_le), 64'd1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_valid", 64'(v_le), 64'd0);
        chk("mid_rst_data_chan", {29'd0, c_le, 32'(d_le)}, 64'd0);
        chk("mid_rst_flags", {61'd0, fd_le, sf_le, ov_le}, 64'd0);
        rst = 1'b0;
        r_le = 1'b1;
        n0 = got_le.size(); f0 = fdn_le; s0 = sfn_le;
        spi_bits(8'h80, 4);
        for (int i = 4; i < 13; i++) spi_bits(fr[i], 8);
        cs_high();
        chk("mid_remainder_words", 64'(got_le.size() - n0), 64'd0);
        chk("mid_remainder_pulses", 64'(fdn_le - f0 + sfn_le - s0), 64'd0);
        cs_low(); send_bytes(); cs_high();
        chk("mid_next_count", 64'(got_le.size() - n0), 64'd6);
        chk("mid_next_w0", 64'(got_le[n0]), 64'(ent(0, 32'h1234)));
        chk("mid_next_w5", 64'(got_le[n0+5]), 64'(ent(5, 32'h7FFF)));

        // 24-bit, single word, no skip phase, extra edges before CS rises
        do_reset();
        n0 = got_w24.size(); f0 = fdn_w24; s0 = sfn_w24;
        fr = '{8'h01, 8'h02, 8'h03, 8'hAA};
        cs_low(); send_bytes(); cs_high();
        chk("w24_count", 64'(got_w24.size() - n0), 64'd1);
        chk("w24_word", 64'(got_w24[n0]), 64'(ent(0, 32'h030201)));
        chk("w24_frame_done", 64'(fdn_w24 - f0), 64'd1);
        chk("w24_no_short", 64'(sfn_w24 - s0), 64'd0);
        chk("w24_empty", 64'(v_w24), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end
endmodule
